// File: rtl/axi4_resp_pkg.sv
// Shared response codes, FSM state encodings and byte/response helpers
// for the AXI4 register-file responder.
package axi4_resp_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] SIZE_WORD = 3'd2;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    // Replace the bytes of old_word selected by strb with those of new_word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] merged;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = strb[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return merged;
    endfunction

    // Out-of-range decode beats a malformed burst.
    function automatic logic [1:0] classify(input logic       in_range,
                                            input logic [7:0] len,
                                            input logic [2:0] size);
        if (!in_range) begin
            return RESP_DECERR;
        end else if ((len != 8'd0) || (size > SIZE_WORD)) begin
            return RESP_SLVERR;
        end else begin
            return RESP_OKAY;
        end
    endfunction

endpackage

// File: rtl/axi4_regfile_core.sv
// NREGS x 32-bit register storage: one byte-strobed write port and one
// combinational read port that sees the value from before a same-cycle write.
module axi4_regfile_core
    import axi4_resp_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int IDX_W = $clog2(NREGS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [31:0]      wr_data,
    input  logic [3:0]       wr_strb,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [31:0]      rd_data
);

    logic [31:0] mem_r [NREGS];

    // Storage array with byte-lane merge on write.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_r[i] <= 32'd0;
            end
        end else if (we) begin
            mem_r[wr_idx] <= merge_bytes(mem_r[wr_idx], wr_data, wr_strb);
        end
    end

    assign rd_data = mem_r[rd_idx];

endmodule

// File: rtl/axi4_regfile_responder.sv
// AXI4 subordinate serving single-beat accesses to a small register file,
// echoing ID/user and answering malformed or out-of-range bursts with errors.
module axi4_regfile_responder
    import axi4_resp_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int NREGS  = 16,
    parameter int ID_W   = 2,
    parameter int USER_W = 7
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              aw_valid,
    output logic              aw_ready,
    input  logic [ID_W-1:0]   aw_id,
    input  logic [ADDR_W-1:0] aw_addr,
    input  logic [7:0]        aw_len,
    input  logic [2:0]        aw_size,
    input  logic [USER_W-1:0] aw_user,
    input  logic              w_valid,
    output logic              w_ready,
    input  logic [31:0]       w_data,
    input  logic [3:0]        w_strb,
    input  logic              w_last,
    output logic              b_valid,
    input  logic              b_ready,
    output logic [ID_W-1:0]   b_id,
    output logic [1:0]        b_resp,
    output logic [USER_W-1:0] b_user,
    input  logic              ar_valid,
    output logic              ar_ready,
    input  logic [ID_W-1:0]   ar_id,
    input  logic [ADDR_W-1:0] ar_addr,
    input  logic [7:0]        ar_len,
    input  logic [2:0]        ar_size,
    input  logic [USER_W-1:0] ar_user,
    output logic              r_valid,
    input  logic              r_ready,
    output logic [ID_W-1:0]   r_id,
    output logic [31:0]       r_data,
    output logic [1:0]        r_resp,
    output logic              r_last,
    output logic [USER_W-1:0] r_user
);

    localparam int IDX_W  = $clog2(NREGS);
    localparam int AIDX_W = ADDR_W - 2;

    w_state_t         w_state_r, w_state_s;
    r_state_t         r_state_r, r_state_s;
    logic [IDX_W-1:0] w_idx_r;
    logic [7:0]       r_cnt_r;
    logic             core_we_s;
    logic [31:0]      core_rd_data_s;
    logic             aw_in_range_s, ar_in_range_s;
    logic [1:0]       aw_class_s, ar_class_s;
    logic             unused_s;

    if (IDX_W < AIDX_W) begin : g_range
        assign aw_in_range_s = (aw_addr[ADDR_W-1:2+IDX_W] == {(AIDX_W-IDX_W){1'b0}});
        assign ar_in_range_s = (ar_addr[ADDR_W-1:2+IDX_W] == {(AIDX_W-IDX_W){1'b0}});
    end else begin : g_full
        assign aw_in_range_s = 1'b1;
        assign ar_in_range_s = 1'b1;
    end

    assign aw_class_s = classify(aw_in_range_s, aw_len, aw_size);
    assign ar_class_s = classify(ar_in_range_s, ar_len, ar_size);
    assign unused_s   = ^{aw_addr[1:0], ar_addr[1:0]};

    axi4_regfile_core #(
        .NREGS (NREGS),
        .IDX_W (IDX_W)
    ) u_core (
        .clock   (clock),
        .reset   (reset),
        .we      (core_we_s),
        .wr_idx  (w_idx_r),
        .wr_data (w_data),
        .wr_strb (w_strb),
        .rd_idx  (ar_addr[2 +: IDX_W]),
        .rd_data (core_rd_data_s)
    );

    // Write FSM next state and commit strobe; b_resp doubles as the latched class.
    always_comb begin
        w_state_s = w_state_r;
        core_we_s = 1'b0;
        case (w_state_r)
            W_IDLE: begin
                if (aw_valid) begin
                    w_state_s = W_DATA;
                end else begin
                    w_state_s = W_IDLE;
                end
            end
            W_DATA: begin
                if (w_valid) begin
                    core_we_s = (b_resp == RESP_OKAY);
                    if (w_last || (b_resp == RESP_OKAY)) begin
                        w_state_s = W_RESP;
                    end else begin
                        w_state_s = W_DATA;
                    end
                end else begin
                    w_state_s = W_DATA;
                end
            end
            W_RESP: begin
                if (b_ready) begin
                    w_state_s = W_IDLE;
                end else begin
                    w_state_s = W_RESP;
                end
            end
            default: w_state_s = W_IDLE;
        endcase
    end

    // Write state, registered handshake flags and latched AW attributes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            w_state_r <= W_IDLE;
            aw_ready  <= 1'b1;
            w_ready   <= 1'b0;
            b_valid   <= 1'b0;
            b_id      <= {ID_W{1'b0}};
            b_user    <= {USER_W{1'b0}};
            b_resp    <= RESP_OKAY;
            w_idx_r   <= {IDX_W{1'b0}};
        end else begin
            w_state_r <= w_state_s;
            aw_ready  <= (w_state_s == W_IDLE);
            w_ready   <= (w_state_s == W_DATA);
            b_valid   <= (w_state_s == W_RESP);
            if ((w_state_r == W_IDLE) && aw_valid) begin
                b_id    <= aw_id;
                b_user  <= aw_user;
                b_resp  <= aw_class_s;
                w_idx_r <= aw_addr[2 +: IDX_W];
            end
        end
    end

    // Read FSM next state: leave R_DATA on the handshake of the last beat.
    always_comb begin
        r_state_s = r_state_r;
        case (r_state_r)
            R_IDLE: begin
                if (ar_valid) begin
                    r_state_s = R_DATA;
                end else begin
                    r_state_s = R_IDLE;
                end
            end
            R_DATA: begin
                if (r_ready && r_last) begin
                    r_state_s = R_IDLE;
                end else begin
                    r_state_s = R_DATA;
                end
            end
            default: r_state_s = R_IDLE;
        endcase
    end

    // Read state, beat counter and R channel outputs, held while stalled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state_r <= R_IDLE;
            ar_ready  <= 1'b1;
            r_valid   <= 1'b0;
            r_id      <= {ID_W{1'b0}};
            r_user    <= {USER_W{1'b0}};
            r_resp    <= RESP_OKAY;
            r_data    <= 32'd0;
            r_last    <= 1'b0;
            r_cnt_r   <= 8'd0;
        end else begin
            r_state_r <= r_state_s;
            ar_ready  <= (r_state_s == R_IDLE);
            r_valid   <= (r_state_s == R_DATA);
            if ((r_state_r == R_IDLE) && ar_valid) begin
                r_id    <= ar_id;
                r_user  <= ar_user;
                r_resp  <= ar_class_s;
                r_cnt_r <= ar_len;
                r_last  <= (ar_len == 8'd0);
                r_data  <= (ar_class_s == RESP_OKAY) ? core_rd_data_s : 32'd0;
            end else if ((r_state_r == R_DATA) && r_ready) begin
                if (r_last) begin
                    r_last <= 1'b0;
                end else begin
                    r_cnt_r <= r_cnt_r - 8'd1;
                    r_last  <= (r_cnt_r == 8'd1);
                end
            end
        end
    end

endmodule

// File: tb/tb_axi4_regfile_responder.sv
// Directed and randomized bench for axi4_regfile_responder, checked against
// an array-based register model and the address/burst error rules.
module tb_axi4_regfile_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        aw_valid = 1'b0, w_valid = 1'b0, b_ready = 1'b0;
    logic        ar_valid = 1'b0, r_ready = 1'b0;
    logic        aw_ready, w_ready, b_valid, ar_ready, r_valid, r_last;
    logic [1:0]  aw_id = 2'd0, ar_id = 2'd0, b_id, r_id, b_resp, r_resp;
    logic [11:0] aw_addr = 12'd0, ar_addr = 12'd0;
    logic [7:0]  aw_len = 8'd0, ar_len = 8'd0;
    logic [2:0]  aw_size = 3'd0, ar_size = 3'd0;
    logic [6:0]  aw_user = 7'd0, ar_user = 7'd0, b_user, r_user;
    logic [31:0] w_data = 32'd0, r_data;
    logic [3:0]  w_strb = 4'd0;
    logic        w_last = 1'b0;

    int          compared = 0;
    int          mismatched = 0;
    logic [31:0] model_mem [16];
    logic [1:0]  exp_bid, exp_bresp;
    logic [6:0]  exp_buser;

    always #5 clock = ~clock;

    axi4_regfile_responder dut (
        .clock(clock), .reset(reset),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_id(aw_id), .aw_addr(aw_addr),
        .aw_len(aw_len), .aw_size(aw_size), .aw_user(aw_user),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
        .b_valid(b_valid), .b_ready(b_ready), .b_id(b_id), .b_resp(b_resp), .b_user(b_user),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_id(ar_id), .ar_addr(ar_addr),
        .ar_len(ar_len), .ar_size(ar_size), .ar_user(ar_user),
        .r_valid(r_valid), .r_ready(r_ready), .r_id(r_id), .r_data(r_data),
        .r_resp(r_resp), .r_last(r_last), .r_user(r_user)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Index beyond the 16 registers is a decode error; any burst or size above a word is a slave error.
    function automatic logic [1:0] ref_class(input logic [11:0] addr, input logic [7:0] len,
                                             input logic [2:0] size);
        if (addr[11:2] >= 10'd16) return 2'b11;
        if (len != 8'd0 || size > 3'd2) return 2'b10;
        return 2'b00;
    endfunction

    task automatic complete_b(input int bdelay);
        b_ready = 1'b0;
        for (int k = 0; k < bdelay; k++) begin
            chk("b_hold_valid", b_valid, 1'b1);
            chk("b_hold_id", b_id, exp_bid);
            chk("b_hold_resp", b_resp, exp_bresp);
            chk("b_hold_aw_ready", aw_ready, 1'b0);
            tick;
        end
        chk("b_valid", b_valid, 1'b1);
        chk("b_id", b_id, exp_bid);
        chk("b_user", b_user, exp_buser);
        chk("b_resp", b_resp, exp_bresp);
        b_ready = 1'b1;
        tick;
        b_ready = 1'b0;
        chk("b_valid_drop", b_valid, 1'b0);
        chk("aw_ready_back", aw_ready, 1'b1);
    endtask

    task automatic do_write(input logic [11:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] id, input logic [6:0] user, input logic [31:0] data,
                            input logic [3:0] strb, input int bdelay, input bit hold_b);
        logic [1:0] cls;
        int n, nb;
        cls = ref_class(addr, len, size);
        nb  = int'(len) + 1;
        aw_valid = 1'b1; aw_addr = addr; aw_len = len; aw_size = size; aw_id = id; aw_user = user;
        n = 0;
        while (!aw_ready && n < 50) begin tick; n++; end
        chk("aw_ready_wait", aw_ready, 1'b1);
        tick;
        aw_valid = 1'b0;
        chk("w_ready_after_aw", w_ready, 1'b1);
        for (int b = 0; b < nb; b++) begin
            w_valid = 1'b1;
            w_data  = (b == 0) ? data : $urandom;
            w_strb  = (b == 0) ? strb : 4'($urandom);
            w_last  = (b == nb - 1);
            if (cls == 2'b00) w_last = 1'($urandom_range(0, 1));
            n = 0;
            while (!w_ready && n < 50) begin tick; n++; end
            chk("w_ready_beat", w_ready, 1'b1);
            tick;
        end
        w_valid = 1'b0;
        w_last  = 1'b0;
        if (cls == 2'b00) begin
            for (int i = 0; i < 4; i++) begin
                if (strb[i]) model_mem[addr[5:2]][8*i +: 8] = data[8*i +: 8];
            end
        end
        chk("b_valid_latency", b_valid, 1'b1);
        exp_bid = id; exp_buser = user; exp_bresp = cls;
        if (!hold_b) complete_b(bdelay);
    endtask

    task automatic do_read(input logic [11:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] id, input logic [6:0] user, input int stall);
        logic [1:0]  cls;
        logic [31:0] expd;
        int n, nb, st;
        cls  = ref_class(addr, len, size);
        expd = (cls == 2'b00) ? model_mem[addr[5:2]] : 32'd0;
        nb   = int'(len) + 1;
        ar_valid = 1'b1; ar_addr = addr; ar_len = len; ar_size = size; ar_id = id; ar_user = user;
        n = 0;
        while (!ar_ready && n < 50) begin tick; n++; end
        chk("ar_ready_wait", ar_ready, 1'b1);
        tick;
        ar_valid = 1'b0;
        for (int k = 0; k < nb; k++) begin
            st = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
            r_ready = 1'b0;
            for (int s = 0; s < st; s++) begin
                chk("r_hold_valid", r_valid, 1'b1);
                chk("r_hold_data", r_data, expd);
                chk("r_hold_last", r_last, (k == nb - 1));
                chk("r_hold_ar_ready", ar_ready, 1'b0);
                tick;
            end
            chk("r_valid", r_valid, 1'b1);
            chk("r_id", r_id, id);
            chk("r_user", r_user, user);
            chk("r_resp", r_resp, cls);
            chk("r_data", r_data, expd);
            chk("r_last", r_last, (k == nb - 1));
            r_ready = 1'b1;
            tick;
            r_ready = 1'b0;
        end
        chk("r_valid_drop", r_valid, 1'b0);
        chk("ar_ready_back", ar_ready, 1'b1);
    endtask

    initial begin
        logic [11:0] ra;
        logic [7:0]  rl;
        logic [31:0] old_val;
        for (int i = 0; i < 16; i++) model_mem[i] = 32'd0;
        tick; tick;
        reset = 1'b0;
        tick;
        chk("rst_aw_ready", aw_ready, 1'b1);
        chk("rst_ar_ready", ar_ready, 1'b1);
        chk("rst_w_ready", w_ready, 1'b0);
        chk("rst_b_valid", b_valid, 1'b0);
        chk("rst_r_valid", r_valid, 1'b0);
        chk("rst_r_last", r_last, 1'b0);
        chk("rst_b_resp", b_resp, 2'b00);
        chk("rst_r_resp", r_resp, 2'b00);
        chk("rst_r_data", r_data, 32'd0);

        do_write(12'h008, 8'd0, 3'd2, 2'd2, 7'h55, 32'hDEADBEEF, 4'hF, 0, 1'b0);
        do_read (12'h008, 8'd0, 3'd2, 2'd1, 7'h12, 0);
        do_write(12'h008, 8'd0, 3'd2, 2'd0, 7'h01, 32'h000000AA, 4'h1, 0, 1'b0);
        do_read (12'h008, 8'd0, 3'd2, 2'd3, 7'h7F, 1);
        do_read (12'h040, 8'd3, 3'd2, 2'd1, 7'h33, 0);
        do_write(12'h040, 8'd1, 3'd2, 2'd1, 7'h44, 32'hFFFFFFFF, 4'hF, 1, 1'b0);
        do_write(12'h010, 8'd1, 3'd2, 2'd3, 7'h66, 32'h12345678, 4'hF, 0, 1'b0);
        do_read (12'h010, 8'd0, 3'd2, 2'd0, 7'h02, 0);
        do_read (12'h008, 8'd0, 3'd3, 2'd2, 7'h03, 0);

        // Write parked in W_RESP while an independent read runs to completion.
        do_write(12'h014, 8'd0, 3'd2, 2'd1, 7'h5A, 32'hCAFEF00D, 4'hF, 0, 1'b1);
        do_read (12'h014, 8'd0, 3'd2, 2'd2, 7'h2B, 5);
        complete_b(5);
        do_read (12'h020, 8'd255, 3'd2, 2'd3, 7'h0F, 0);

        for (int it = 0; it < 40; it++) begin
            ra = 12'($urandom_range(0, 19) * 4 + $urandom_range(0, 3));
            rl = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3)) : 8'd0;
            if ($urandom_range(0, 1) == 0) begin
                do_write(ra, rl, 3'($urandom_range(0, 3)), 2'($urandom), 7'($urandom),
                         $urandom, 4'($urandom), int'($urandom_range(0, 2)), 1'b0);
            end else begin
                do_read(ra, rl, 3'($urandom_range(0, 3)), 2'($urandom), 7'($urandom), -1);
            end
        end

        // Same-cycle W commit and AR accept on index 3: read must see the old word.
        do_write(12'h00C, 8'd0, 3'd2, 2'd1, 7'h11, 32'h11111111, 4'hF, 0, 1'b0);
        aw_valid = 1'b1; aw_addr = 12'h00C; aw_len = 8'd0; aw_size = 3'd2; aw_id = 2'd2; aw_user = 7'h21;
        chk("col_aw_ready", aw_ready, 1'b1);
        tick;
        aw_valid = 1'b0;
        w_valid = 1'b1; w_data = 32'h22222222; w_strb = 4'hF; w_last = 1'b1;
        ar_valid = 1'b1; ar_addr = 12'h00C; ar_len = 8'd0; ar_size = 3'd2; ar_id = 2'd3; ar_user = 7'h22;
        chk("col_w_ready", w_ready, 1'b1);
        chk("col_ar_ready", ar_ready, 1'b1);
        tick;
        w_valid = 1'b0; w_last = 1'b0; ar_valid = 1'b0;
        old_val = model_mem[3];
        model_mem[3] = 32'h22222222;
        chk("col_r_valid", r_valid, 1'b1);
        chk("col_r_data", r_data, old_val);
        chk("col_r_last", r_last, 1'b1);
        r_ready = 1'b1;
        tick;
        r_ready = 1'b0;
        exp_bid = 2'd2; exp_buser = 7'h21; exp_bresp = 2'b00;
        complete_b(0);
        do_read(12'h00C, 8'd0, 3'd2, 2'd0, 7'h23, 0);

        // Reset during a multi-beat read drops r_valid asynchronously.
        ar_valid = 1'b1; ar_addr = 12'h044; ar_len = 8'd3; ar_size = 3'd2; ar_id = 2'd1; ar_user = 7'h09;
        tick;
        ar_valid = 1'b0;
        chk("mid_r_valid", r_valid, 1'b1);
        chk("mid_r_resp", r_resp, ref_class(12'h044, 8'd3, 3'd2));
        tick;
        reset = 1'b1;
        #1;
        chk("mid_rst_r_valid", r_valid, 1'b0);
        chk("mid_rst_ar_ready", ar_ready, 1'b1);
        chk("mid_rst_aw_ready", aw_ready, 1'b1);
        chk("mid_rst_r_last", r_last, 1'b0);
        tick;
        reset = 1'b0;
        tick;
        chk("post_rst_r_valid", r_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
